// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned WIDTHxWIDTH->2*WIDTH shift-and-add multiplier controller.
// It drives one shared external adder: one add per RUN cycle, WIDTH cycles per product.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nz,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;

  // Handshake: start is sampled only while busy=0 (IDLE or DONE). busy is high for
  // exactly the RUN cycles; done pulses one cycle when product is valid. product
  // holds until the next accepted start, which may land in the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            acc_hi <= '0;
            if (op_a != '0 && op_b != '0) begin
              mcand  <= op_a;
              acc_lo <= op_b;
              cnt    <= '0;
              state  <= S_RUN;
              busy   <= 1'b1;
            end else begin
              // Zero operand: product is known, skip the adder entirely.
              acc_lo <= '0;
              state  <= S_DONE;
              done   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Carry-out lands in the accumulator MSB, so the shift never drops a bit.
          {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign add_a     = (state == S_RUN) ? acc_hi : '0;
  assign add_b     = (state == S_RUN && acc_lo[0]) ? mcand : '0;
  assign add_cin   = 1'b0;
  assign product   = {acc_hi, acc_lo};
  assign hi_nz     = |acc_hi;
  assign dbg_state = state;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural 32-bit adder beside it.
// Hand-computed products, latencies and handshake timing are checked by assertions.
module tb_mul_seq_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           hi_nz;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;
  int lat;
  int bcnt;
  bit addb_ok;
  int done_seen;

  mul_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .hi_nz(hi_nz),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .dbg_state(dbg_state)
  );

  // External ripple adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents start for one edge; returns in the cycle after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle after the accepting edge. Returns in the done cycle.
  task automatic wait_done(input int inj, input bit chk_addb, input logic [W-1:0] exp_addb);
    lat     = 0;
    bcnt    = 0;
    addb_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) begin
        bcnt++;
        if (add_cin !== 1'b0) addb_ok = 1'b0;
        if (chk_addb && add_b !== exp_addb) addb_ok = 1'b0;
      end
      if (n == inj) begin
        start = 1'b1;
        op_a  = 32'd2;
        op_b  = 32'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (lat == 0) check("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_hi_nz", 64'(hi_nz), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    tick();

    // Basic 3 x 5
    launch(32'd3, 32'd5);
    check("basic_busy_first", 64'(busy), 64'd1);
    wait_done(0, 1'b0, '0);
    check("basic_latency", 64'(lat), 64'd33);
    check("basic_busy_cycles", 64'(bcnt), 64'd32);
    check("basic_product", product, 64'h0000_0000_0000_000F);
    check("basic_hi_nz", 64'(hi_nz), 64'd0);
    check("basic_cin_zero", 64'(addb_ok), 64'd1);
    tick();
    check("basic_done_pulse", 64'(done), 64'd0);
    check("basic_idle_state", 64'(dbg_state), 64'd0);
    check("basic_product_held", product, 64'h0000_0000_0000_000F);
    tick();

    // Max operands: multiplier is all ones, so add_b is mcand every cycle
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, 1'b1, 32'hFFFF_FFFF);
    check("max_latency", 64'(lat), 64'd33);
    check("max_product", product, 64'hFFFF_FFFE_0000_0001);
    check("max_hi_nz", 64'(hi_nz), 64'd1);
    check("max_addb_cin", 64'(addb_ok), 64'd1);
    tick();

    // All-ones times one stays within the low word
    launch(32'hFFFF_FFFF, 32'd1);
    wait_done(0, 1'b0, '0);
    check("one_product", product, 64'h0000_0000_FFFF_FFFF);
    check("one_hi_nz", 64'(hi_nz), 64'd0);
    tick();

    // Zero shortcut, op_b zero
    launch(32'h1234_5678, 32'd0);
    check("zero_b_done", 64'(done), 64'd1);
    check("zero_b_busy", 64'(busy), 64'd0);
    check("zero_b_product", product, 64'd0);
    check("zero_b_add_a", 64'(add_a), 64'd0);
    check("zero_b_add_b", 64'(add_b), 64'd0);
    tick();
    check("zero_b_done_pulse", 64'(done), 64'd0);

    // Zero shortcut, op_a zero
    launch(32'd0, 32'd5);
    check("zero_a_done", 64'(done), 64'd1);
    check("zero_a_product", product, 64'd0);
    tick();

    // Start during RUN is ignored
    launch(32'd7, 32'd9);
    wait_done(10, 1'b0, '0);
    check("ignore_latency", 64'(lat), 64'd33);
    check("ignore_product", product, 64'd63);

    // Back-to-back: start held during the DONE cycle
    launch(32'd7, 32'd9);
    wait_done(0, 1'b0, '0);
    check("b2b_first_product", product, 64'd63);
    check("b2b_first_done", 64'(done), 64'd1);
    launch(32'h0001_0000, 32'h0001_0000);
    check("b2b_no_gap_busy", 64'(busy), 64'd1);
    wait_done(0, 1'b0, '0);
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_product", product, 64'h0000_0001_0000_0000);
    check("b2b_hi_nz", 64'(hi_nz), 64'd1);
    tick();

    // Reset mid-run discards the partial product
    launch(32'h0000_ABCD, 32'h0000_1234);
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_product", product, 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    launch(32'h0000_ABCD, 32'h0000_1234);
    wait_done(0, 1'b0, '0);
    check("after_rst_latency", 64'(lat), 64'd33);
    check("after_rst_product", product, 64'h0000_0000_0C37_4FA4);
    check("after_rst_hi_nz", 64'(hi_nz), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
